// File: rtl/sdram_arbit_mc.sv
// -----------------------------------------------------------------------------
// sdram_arbit_mc
//
// Multi-channel SDRAM command arbiter. It sequences power-up initialisation and
// then arbitrates between auto-refresh and NUM_CH generic access channels
// (write or read engines). Selection is round-robin (RR_EN=1) or fixed
// priority, lowest index first (RR_EN=0). Refresh always beats the channels.
// The owner of the SDRAM command/bank/address bus is chosen combinationally
// from the current state. A refresh request that waits too long sets a
// status flag.
//
// Ports:
//   sys_clk, sys_rst_n            clock, asynchronous active-low reset
//   init_cmd/bank/addr, init_end  init-engine bus and completion flag
//   atref_req, atref_end          refresh request (level) and done pulse
//   atref_cmd/bank/addr           refresh-engine bus
//   ch_req, ch_end                per-channel request (level) and burst-done pulse
//   ch_cmd/bank/addr              flattened per-channel buses, channel i at slice i
//   atref_en, ch_en               registered engine enables (ch_en is one-hot)
//   sdram_cke                     tied high
//   sdram_cmd/bank/addr           muxed SDRAM bus
//   cur_state                     arbiter state (debug)
//   grant_id                      current or last granted channel
//   ref_late                      refresh overdue flag
// -----------------------------------------------------------------------------
module sdram_arbit_mc #(
    parameter int NUM_CH       = 4,
    parameter int CMD_W        = 4,
    parameter int BA_W         = 2,
    parameter int ADDR_W       = 12,
    parameter int RR_EN        = 1,
    parameter int REF_WAIT_MAX = 64,
    localparam int GW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [CMD_W-1:0]         init_cmd,
    input  logic [BA_W-1:0]          init_bank,
    input  logic [ADDR_W-1:0]        init_addr,
    input  logic                     init_end,
    input  logic                     atref_req,
    input  logic                     atref_end,
    input  logic [CMD_W-1:0]         atref_cmd,
    input  logic [BA_W-1:0]          atref_bank,
    input  logic [ADDR_W-1:0]        atref_addr,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_end,
    input  logic [NUM_CH*CMD_W-1:0]  ch_cmd,
    input  logic [NUM_CH*BA_W-1:0]   ch_bank,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    output logic                     atref_en,
    output logic [NUM_CH-1:0]        ch_en,
    output logic                     sdram_cke,
    output logic [CMD_W-1:0]         sdram_cmd,
    output logic [BA_W-1:0]          sdram_bank,
    output logic [ADDR_W-1:0]        sdram_addr,
    output logic [1:0]               cur_state,
    output logic [GW-1:0]            grant_id,
    output logic                     ref_late
);

    localparam int RCW = $clog2(REF_WAIT_MAX + 1);
    localparam logic [CMD_W-1:0] CMD_NOP = CMD_W'(4'b0111);
    localparam logic [RCW-1:0]   REF_MAX = RCW'(REF_WAIT_MAX);

    typedef enum logic [1:0] {
        INIT         = 2'd0,
        ARBIT        = 2'd1,
        AUTO_REFRESH = 2'd2,
        ACCESS       = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             win_vld;
    logic [GW-1:0]    win_id;
    logic [GW-1:0]    scan_id;
    logic [RCW-1:0]   ref_cnt;
    logic [NUM_CH-1:0] ch_en_nxt;

    // Unpacked views of the flattened channel buses so the mux can index by grant_id.
    logic [CMD_W-1:0]  ch_cmd_a  [NUM_CH];
    logic [BA_W-1:0]   ch_bank_a [NUM_CH];
    logic [ADDR_W-1:0] ch_addr_a [NUM_CH];

    // Counter that sticks at its ceiling instead of wrapping.
    function automatic logic [RCW-1:0] sat_inc(input logic [RCW-1:0] v);
        return (v == REF_MAX) ? v : v + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_cmd_a[g]  = ch_cmd[g*CMD_W +: CMD_W];
        assign ch_bank_a[g] = ch_bank[g*BA_W +: BA_W];
        assign ch_addr_a[g] = ch_addr[g*ADDR_W +: ADDR_W];
    end

    assign sdram_cke = 1'b1;
    assign cur_state = state;
    assign ref_late  = (ref_cnt == REF_MAX);

    // Winner selection. Round-robin scans from the slot after the last grant,
    // so the reset value NUM_CH-1 makes channel 0 the first winner.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        scan_id = '0;
        if (RR_EN != 0) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                scan_id = GW'((int'(grant_id) + k) % NUM_CH);
                if (!win_vld && ch_req[scan_id]) begin
                    win_vld = 1'b1;
                    win_id  = scan_id;
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (ch_req[i]) begin
                    win_vld = 1'b1;
                    win_id  = GW'(i);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:         if (init_end) state_nxt = ARBIT;
            ARBIT: begin
                if (atref_req)    state_nxt = AUTO_REFRESH;
                else if (win_vld) state_nxt = ACCESS;
            end
            AUTO_REFRESH: if (atref_end) state_nxt = ARBIT;
            ACCESS:       if (ch_end[grant_id]) state_nxt = ARBIT;
            default:      state_nxt = ARBIT;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= INIT;
            grant_id <= GW'(NUM_CH - 1);
        end else begin
            state <= state_nxt;
            // The pointer only moves on a channel grant, never on refresh.
            if (state == ARBIT && !atref_req && win_vld)
                grant_id <= win_id;
        end
    end

    always_comb begin
        ch_en_nxt = '0;
        for (int i = 0; i < NUM_CH; i++)
            ch_en_nxt[i] = (state == ACCESS) && (grant_id == GW'(i));
    end

    // Enables lag cur_state by one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            atref_en <= 1'b0;
            ch_en    <= '0;
        end else begin
            atref_en <= (state == AUTO_REFRESH);
            ch_en    <= ch_en_nxt;
        end
    end

    // Wait counter is cleared on the edge that enters AUTO_REFRESH so the
    // flag is already low in the first refresh cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ref_cnt <= '0;
        end else if (!atref_req) begin
            ref_cnt <= '0;
        end else if (state != AUTO_REFRESH) begin
            if (state_nxt == AUTO_REFRESH) ref_cnt <= '0;
            else                           ref_cnt <= sat_inc(ref_cnt);
        end
    end

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_bank = '0;
        sdram_addr = '0;
        case (state)
            INIT: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            AUTO_REFRESH: begin
                sdram_cmd  = atref_cmd;
                sdram_bank = atref_bank;
                sdram_addr = atref_addr;
            end
            ACCESS: begin
                sdram_cmd  = ch_cmd_a[grant_id];
                sdram_bank = ch_bank_a[grant_id];
                sdram_addr = ch_addr_a[grant_id];
            end
            default: ;
        endcase
    end

endmodule

// File: doc/sdram_arbit_mc.md
# sdram_arbit_mc

Multi-channel SDRAM command arbiter, parametrised successor of the single write/read-port arbiter. It sequences power-up initialisation, then arbitrates between auto-refresh and NUM_CH generic access channels (write or read engines) with round-robin or fixed-priority selection. It drives the SDRAM command/bank/address bus from whichever source currently owns it, and it flags refresh requests that have waited too long. It sits between the init, auto-refresh and per-channel access engines and the SDRAM pins.

## Interface

Parameters:
- NUM_CH, 4: number of access channels, legal range 1..8.
- CMD_W, 4: command width {cs_n, ras_n, cas_n, we_n}.
- BA_W, 2: bank address width.
- ADDR_W, 12: row/column address width.
- RR_EN, 1: 1 selects round-robin; 0 selects fixed priority (lowest index wins).
- REF_WAIT_MAX, 64: cycles atref_req may wait before ref_late asserts.

Ports (GW = max(1, clog2(NUM_CH))):
- sys_clk  in  1  single clock, all logic on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- init_cmd / init_bank / init_addr  in  CMD_W / BA_W / ADDR_W  init-engine bus.
- init_end  in  1  initialisation complete.
- atref_req  in  1  refresh request, held high until serviced.
- atref_end  in  1  refresh sequence done.
- atref_cmd / atref_bank / atref_addr  in  CMD_W / BA_W / ADDR_W  refresh-engine bus.
- ch_req  in  NUM_CH  per-channel access request, level.
- ch_end  in  NUM_CH  per-channel one-burst-complete pulse.
- ch_cmd / ch_bank / ch_addr  in  NUM_CH*CMD_W / NUM_CH*BA_W / NUM_CH*ADDR_W  flattened channel buses, channel i at slice i.
- atref_en  out  1  refresh engine enable.
- ch_en  out  NUM_CH  one-hot channel enable.
- sdram_cke  out  1  constant 1.
- sdram_cmd / sdram_bank / sdram_addr  out  CMD_W / BA_W / ADDR_W  muxed SDRAM bus.
- cur_state  out  2  state, for debug.
- grant_id  out  GW  currently or last granted channel.
- ref_late  out  1  refresh overdue flag.

## Operation

- State encoding: INIT=0, ARBIT=1, AUTO_REFRESH=2, ACCESS=3. Any illegal state goes to ARBIT.
- INIT: init_end=1 moves to ARBIT.
- ARBIT, evaluated in priority order:
  - atref_req=1 moves to AUTO_REFRESH. Refresh always beats channels.
  - Otherwise, any ch_req bit set moves to ACCESS. grant_id is loaded with the winner on the same edge.
  - Otherwise, stay in ARBIT.
- Winner selection:
  - RR_EN=1: scan starting at (grant_id+1) mod NUM_CH and wrap. grant_id resets to NUM_CH-1, so channel 0 wins first.
  - RR_EN=0: lowest set index wins.
- ACCESS: ch_end[grant_id]=1 returns to ARBIT. ch_end on non-granted channels is ignored. An access is never aborted; refresh waits for ch_end.
- AUTO_REFRESH: atref_end=1 returns to ARBIT.
- Every operation passes through ARBIT for at least 1 cycle.
- Enables are registered from cur_state:
  - atref_en <= (cur_state==AUTO_REFRESH).
  - ch_en[i] <= (cur_state==ACCESS && grant_id==i).
- Bus mux is combinational on cur_state:
  - INIT: init_* sources the bus.
  - AUTO_REFRESH: atref_* sources the bus.
  - ACCESS: slice grant_id of ch_* sources the bus.
  - ARBIT: sdram_cmd=4'b0111 (NOP), sdram_bank=0, sdram_addr=0.
- ref_late:
  - Saturating counter increments each cycle atref_req=1 and cur_state!=AUTO_REFRESH.
  - Counter clears on entry to AUTO_REFRESH and whenever atref_req=0.
  - ref_late=1 when the counter equals REF_WAIT_MAX. It is a status flag only and does not change arbitration.

## Timing

- Reset values: cur_state=INIT, grant_id=NUM_CH-1, atref_en=0, ch_en=0, ref_late=0, ref counter=0, sdram_cke=1. Bus outputs follow init_* while in INIT.
- Reset asserted mid-operation: immediate return to reset values. Full re-initialisation is required.
- Grant latency:
  - Request seen in ARBIT at edge t gives cur_state/grant_id updated at t+1 and en=1 at t+2.
  - End pulse at edge t gives cur_state=ARBIT at t+1 and en=0 at t+2.
- atref_req and ch_req are simultaneous in ARBIT: refresh wins. The channel is granted on the next ARBIT visit. Round-robin pointer is unchanged by refresh.
- ch_end coincident with atref_req: ARBIT for 1 cycle, then AUTO_REFRESH.
- NUM_CH=1: grant_id is constant 0 and round-robin reduces to a single channel.

## Test plan

- Init: hold init_end=0 for 20 cycles, then pulse it -> sdram_cmd tracks init_cmd throughout; cur_state=1 on the next cycle; all en=0.
- Single channel: ch_req=4'b0100 -> cur_state=3 and grant_id=2 one cycle later; ch_en=4'b0100 one cycle after that; sdram_addr equals ch_addr slice 2; ch_end[2] -> ch_en=0 two cycles later.
- Round-robin, RR_EN=1: ch_req=4'b1111 held, each burst 5 cycles -> grant order 0,1,2,3,0; ch_end on a non-granted channel is ignored.
- Fixed priority, RR_EN=0: ch_req=4'b1010 held -> channel 1 is granted repeatedly and channel 3 is never granted.
- Refresh during access: atref_req rises while channel 0 is in ACCESS, with ch_req=4'b0011 -> AUTO_REFRESH follows ch_end[0] after 1 ARBIT cycle; channel 1 is granted after atref_end.
- ref_late and reset: REF_WAIT_MAX=8, access 12 cycles long with atref_req waiting -> ref_late=1 after 8 waiting cycles and 0 on AUTO_REFRESH entry; sys_rst_n low mid-ACCESS -> all outputs at reset values immediately.
